// File: rtl/teensy_tx_arbiter_if.sv
// teensy_tx_arbiter_if: handshake bundle between two packet requesters, the packet
// arbiter and the byte-wide RS-232C transmitter.
//   Req0/Pkt0/Ack0  requester 0 packet handshake (Ack is a one-cycle pulse)
//   Req1/Pkt1/Ack1  requester 1 packet handshake
//   TransBusy       transmitter busy (t_busy)
//   EnTrans         one-cycle transmit strobe (te)
//   TransData       byte presented with EnTrans
//   Busy/Owner/Done arbiter status
// Modports: master = arbiter side, slave = requester/transmitter side.
interface teensy_tx_arbiter_if #(
  parameter int unsigned PKT_BYTES = 9
) ();
  logic                   Req0;
  logic [PKT_BYTES*8-1:0] Pkt0;
  logic                   Ack0;
  logic                   Req1;
  logic [PKT_BYTES*8-1:0] Pkt1;
  logic                   Ack1;
  logic                   TransBusy;
  logic                   EnTrans;
  logic [7:0]             TransData;
  logic                   Busy;
  logic                   Owner;
  logic                   Done;

  modport master (
    input  Req0, Pkt0, Req1, Pkt1, TransBusy,
    output Ack0, Ack1, EnTrans, TransData, Busy, Owner, Done
  );

  modport slave (
    output Req0, Pkt0, Req1, Pkt1, TransBusy,
    input  Ack0, Ack1, EnTrans, TransData, Busy, Owner, Done
  );
endinterface

// File: rtl/teensy_tx_arbiter.sv
// teensy_tx_arbiter: packet-level scheduler sharing one byte-wide RS-232C transmitter
// between two requesters. A granted packet is latched whole, then sent byte 0 first,
// one EnTrans strobe per byte, pacing on the transmitter's busy flag.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   arb_io  teensy_tx_arbiter_if.master (requester handshakes, transmitter handshake,
//           Busy/Owner/Done status); all outputs registered
// Configuration macro: TX_ARB_ROUND_ROBIN_EN
//   defined   - on a tie the requester not served last wins (first tie goes to 0)
//   undefined - fixed priority, requester 0 wins ties
module teensy_tx_arbiter #(
  parameter int unsigned PKT_BYTES    = 9,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  teensy_tx_arbiter_if.master arb_io
);
  localparam int unsigned PktW = PKT_BYTES * 8;
  localparam int unsigned CntW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int unsigned GrdW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CntW-1:0] LastIdx   = CntW'(PKT_BYTES - 1);
  localparam logic [GrdW-1:0] GuardLoad = GrdW'(GUARD_CYCLES);

  typedef enum logic [1:0] {StIdle, StHold, StWait} state_e;

  state_e          state_q, state_d;
  logic [PktW-1:0] shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GrdW-1:0] guard_q, guard_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            en_q, en_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            owner_q, owner_d;
  logic            done_q, done_d;
  logic            grant0, grant1;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  // last_q = requester served last; a tie goes to the other one
  assign grant1 = arb_io.Req1 && (!arb_io.Req0 || !last_q);
`else
  assign grant1 = arb_io.Req1 && !arb_io.Req0;
`endif
  assign grant0 = arb_io.Req0 && !grant1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    guard_d = guard_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    en_d    = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    done_d  = 1'b0;
`ifdef TX_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!arb_io.TransBusy && (grant0 || grant1)) begin
          shift_d = grant1 ? arb_io.Pkt1 : arb_io.Pkt0;
          ack0_d  = grant0;
          ack1_d  = grant1;
          owner_d = grant1;
`ifdef TX_ARB_ROUND_ROBIN_EN
          last_d  = grant1;
`endif
          en_d    = 1'b1;
          data_d  = shift_d[7:0];
          cnt_d   = '0;
          guard_d = GuardLoad;
          state_d = StHold;
        end
      end
      StHold: begin
        // TransBusy is ignored here: the transmitter may not have raised it yet
        if (guard_q == '0) begin
          state_d = StWait;
        end else begin
          guard_d = guard_q - GrdW'(1);
        end
      end
      StWait: begin
        if (!arb_io.TransBusy) begin
          if (cnt_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            shift_d = shift_q >> 8;
            data_d  = shift_d[7:0];
            cnt_d   = cnt_q + CntW'(1);
            en_d    = 1'b1;
            guard_d = GuardLoad;
            state_d = StHold;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      guard_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      done_q  <= done_d;
`ifdef TX_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  assign arb_io.Ack0      = ack0_q;
  assign arb_io.Ack1      = ack1_q;
  assign arb_io.EnTrans   = en_q;
  assign arb_io.TransData = data_q;
  assign arb_io.Busy      = busy_q;
  assign arb_io.Owner     = owner_q;
  assign arb_io.Done      = done_q;
endmodule

// File: tb/tb_teensy_tx_arbiter.sv
// Bench for teensy_tx_arbiter: table of packet requests plus directed sequences for
// late requests, stalled transmitter, mid-packet reset and withdrawn requests.
module tb_teensy_tx_arbiter;
  localparam int unsigned PktBytes    = 9;
  localparam int unsigned GuardCycles = 2;
  localparam int          TxBusyLen   = 10;
  // te at t, busy high t+1..t+TxBusyLen, sampled low at end of t+TxBusyLen+1
  localparam int          ByteGap     = TxBusyLen + 2;

  localparam logic [71:0] PktA = 72'h0807060504030201FF;
  localparam logic [71:0] PktB = 72'h112233445566778899;
  localparam logic [71:0] PktC = 72'hA1A2A3A4A5A6A7A8A9;
  localparam logic [71:0] PktD = 72'hB1B2B3B4B5B6B7B8B9;

  typedef struct {
    logic        req0;
    logic        req1;
    logic [71:0] pkt0;
    logic [71:0] pkt1;
    logic        exp_fixed;
    logic        exp_rr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_busy = 1'b0;
  int   tx_cnt;
  int   n_checks = 0;
  int   n_fail = 0;

  teensy_tx_arbiter_if #(.PKT_BYTES(PktBytes)) bus ();

  teensy_tx_arbiter #(
    .PKT_BYTES   (PktBytes),
    .GUARD_CYCLES(GuardCycles)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .arb_io(bus.master)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy from 1 cycle after te for TxBusyLen cycles
  always @(posedge clk or posedge rst) begin
    if (rst) tx_cnt <= 0;
    else if (bus.EnTrans) tx_cnt <= TxBusyLen;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign bus.TransBusy = force_busy | (tx_cnt != 0);

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.Ack0 || bus.Ack1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge of the Ack cycle; returns at the negedge of the Done cycle.
  // Actions a/b set the request lines when byte index a_idx/b_idx is strobed.
  task automatic run_packet(input logic [71:0] exp_pkt,
                            input int a_idx, input logic a_r0, input logic a_r1,
                            input int b_idx, input logic b_r0, input logic b_r1);
    int   nbytes = 0;
    int   last_t = 0;
    logic extra = 1'b0;
    logic done_seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (cyc != 0 && (bus.Ack0 || bus.Ack1)) extra = 1'b1;
      if (bus.EnTrans) begin
        if (nbytes < int'(PktBytes))
          check("tx_byte", 72'(bus.TransData), 72'(exp_pkt[8*nbytes +: 8]));
        if (nbytes > 0) check("byte_gap", 72'(cyc - last_t), 72'(ByteGap));
        last_t = cyc;
        if (nbytes == a_idx) begin bus.Req0 = a_r0; bus.Req1 = a_r1; end
        if (nbytes == b_idx) begin bus.Req0 = b_r0; bus.Req1 = b_r1; end
        nbytes++;
      end
      if (bus.Done) begin
        done_seen = 1'b1;
        break;
      end
    end
    check("done_seen", 72'(done_seen), 72'(1));
    check("byte_count", 72'(nbytes), 72'(PktBytes));
    check("no_ack_in_flight", 72'(extra), 72'(0));
    check("busy_low_at_done", 72'(bus.Busy), 72'(0));
  endtask

  vec_t vecs[6];

  initial begin
    logic got;
    logic exp_w;
    int   nb;
    int   acks;

    vecs[0] = '{req0: 1'b1, req1: 1'b0, pkt0: PktA, pkt1: PktB, exp_fixed: 1'b0, exp_rr: 1'b0};
    vecs[1] = '{req0: 1'b0, req1: 1'b1, pkt0: PktB, pkt1: PktC, exp_fixed: 1'b1, exp_rr: 1'b1};
    vecs[2] = '{req0: 1'b1, req1: 1'b1, pkt0: PktA, pkt1: PktD, exp_fixed: 1'b0, exp_rr: 1'b0};
    vecs[3] = '{req0: 1'b1, req1: 1'b1, pkt0: PktA, pkt1: PktD, exp_fixed: 1'b0, exp_rr: 1'b1};
    vecs[4] = '{req0: 1'b1, req1: 1'b1, pkt0: PktA, pkt1: PktD, exp_fixed: 1'b0, exp_rr: 1'b0};
    vecs[5] = '{req0: 1'b1, req1: 1'b1, pkt0: PktA, pkt1: PktD, exp_fixed: 1'b0, exp_rr: 1'b1};

    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    bus.Pkt0 = '0;
    bus.Pkt1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack0", 72'(bus.Ack0), 72'(0));
    check("rst_ack1", 72'(bus.Ack1), 72'(0));
    check("rst_entrans", 72'(bus.EnTrans), 72'(0));
    check("rst_data", 72'(bus.TransData), 72'(0));
    check("rst_busy", 72'(bus.Busy), 72'(0));
    check("rst_owner", 72'(bus.Owner), 72'(0));
    check("rst_done", 72'(bus.Done), 72'(0));

    // Table: each record is applied at the negedge of the previous Done (or idle)
    for (int i = 0; i < 6; i++) begin
`ifdef TX_ARB_ROUND_ROBIN_EN
      exp_w = vecs[i].exp_rr;
`else
      exp_w = vecs[i].exp_fixed;
`endif
      bus.Req0 = vecs[i].req0;
      bus.Req1 = vecs[i].req1;
      bus.Pkt0 = vecs[i].pkt0;
      bus.Pkt1 = vecs[i].pkt1;
      wait_ack(got);
      check("vec_ack_seen", 72'(got), 72'(1));
      check("vec_ack0", 72'(bus.Ack0), 72'(!exp_w));
      check("vec_ack1", 72'(bus.Ack1), 72'(exp_w));
      check("vec_owner", 72'(bus.Owner), 72'(exp_w));
      check("vec_busy", 72'(bus.Busy), 72'(1));
      run_packet(exp_w ? vecs[i].pkt1 : vecs[i].pkt0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    end
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    @(negedge clk);
    check("owner_holds_idle", 72'(bus.Owner), 72'(exp_w));
    check("idle_entrans", 72'(bus.EnTrans), 72'(0));
    check("data_holds_last", 72'(bus.TransData), 72'(exp_w ? PktD[71:64] : PktA[71:64]));

    // Req1 raised during the 5th byte of a requester-0 packet
    bus.Req0 = 1'b1;
    bus.Pkt0 = PktA;
    bus.Pkt1 = PktC;
    wait_ack(got);
    check("late_ack0", 72'(bus.Ack0), 72'(1));
    run_packet(PktA, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    @(negedge clk);
    check("late_ack1_after_done", 72'(bus.Ack1), 72'(1));
    check("late_owner", 72'(bus.Owner), 72'(1));
    check("late_byte0", 72'(bus.TransData), 72'(PktC[7:0]));
    run_packet(PktC, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Transmitter busy in idle blocks the grant
    force_busy = 1'b1;
    bus.Req0 = 1'b1;
    bus.Pkt0 = PktD;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Ack0 || bus.Ack1) acks++;
    end
    check("busy_blocks_ack", 72'(acks), 72'(0));
    force_busy = 1'b0;
    @(negedge clk);
    check("ack_after_busy_drop", 72'(bus.Ack0), 72'(1));
    run_packet(PktD, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Reset after the 3rd byte
    bus.Req0 = 1'b1;
    bus.Pkt0 = PktC;
    wait_ack(got);
    check("rst_seq_ack", 72'(bus.Ack0), 72'(1));
    nb = 0;
    for (int i = 0; i < 200 && nb < 3; i++) begin
      if (i != 0) @(negedge clk);
      if (bus.EnTrans) nb++;
    end
    check("rst_seq_three_bytes", 72'(nb), 72'(3));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_entrans", 72'(bus.EnTrans), 72'(0));
    check("midrst_busy", 72'(bus.Busy), 72'(0));
    check("midrst_done", 72'(bus.Done), 72'(0));
    bus.Pkt0 = PktA;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(got);
    check("restart_ack0", 72'(bus.Ack0), 72'(1));
    check("restart_byte0", 72'(bus.TransData), 72'(8'hFF));
    run_packet(PktA, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    // Req0 withdrawn in the same cycle Req1 rises while busy
    bus.Req1 = 1'b1;
    bus.Pkt1 = PktB;
    wait_ack(got);
    check("wd_first_ack1", 72'(bus.Ack1), 72'(1));
    run_packet(PktB, 0, 1'b1, 1'b0, 3, 1'b0, 1'b1);
    @(negedge clk);
    check("wd_ack1_after_done", 72'(bus.Ack1), 72'(1));
    check("wd_no_ack0", 72'(bus.Ack0), 72'(0));
    run_packet(PktB, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/teensy_tx_arbiter.md
# teensy_tx_arbiter

Packet-level scheduler sharing one byte-wide RS-232C transmitter between two packet requesters, e.g. the tremor position stream and a status/telemetry stream bound for the Teensy. Each requester hands over a complete `PKT_BYTES` packet with a req/ack handshake. The arbiter selects one requester, latches its packet, and serializes it byte by byte to the transmitter over its `te`/`t_busy` handshake. It sits between the packet generators and `rs232c_transmitter`.

## Interface
Parameters:
- `PKT_BYTES`, 9: bytes per packet; byte k is bits `[8k+7:8k]` and byte 0 is sent first.
- `GUARD_CYCLES`, 2: cycles ignored after each `EnTrans` pulse before `TransBusy` is sampled (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `Req0` in 1: requester 0 has a packet pending (level).
- `Pkt0` in `PKT_BYTES*8`: requester 0 packet.
- `Ack0` out 1: one-cycle pulse; `Pkt0` was latched on the preceding edge.
- `Req1` in 1: requester 1 has a packet pending.
- `Pkt1` in `PKT_BYTES*8`: requester 1 packet.
- `Ack1` out 1: as `Ack0`, for requester 1.
- `TransBusy` in 1: transmitter busy (`t_busy`).
- `EnTrans` out 1: one-cycle transmit strobe (`te`).
- `TransData` out 8: byte presented with `EnTrans`.
- `Busy` out 1: a packet is in flight.
- `Owner` out 1: requester currently being served; holds its last value when idle.
- `Done` out 1: one-cycle pulse after the last byte completes.

## Operation
- States: IDLE, HOLD, WAIT.
- **IDLE**
  - Arbitrate when `TransBusy`=0 and either `Req` is high.
  - On the winning edge:
    - latch the winner's packet into the shift register;
    - set `Ack` of the winner to 1 and `Owner` to the winner;
    - set `EnTrans`=1 and `TransData`=byte 0;
    - set the byte counter to 0 and the guard counter to `GUARD_CYCLES`;
    - go to HOLD.
  - If `TransBusy`=1, stay in IDLE and issue no `Ack`.
- **HOLD**: decrement the guard counter; `TransBusy` is ignored. At 0, go to WAIT.
- **WAIT**: wait for `TransBusy`=0.
  - If byte counter = `PKT_BYTES-1`: pulse `Done`, go to IDLE.
  - Otherwise: shift right 8, increment the counter, pulse `EnTrans` with the next byte, reload the guard counter, go to HOLD.
- Arbitration without the macro: fixed priority; `Req0` wins ties.
- Requester contract:
  - Hold `Req` and `Pkt` stable until `Ack`.
  - Deasserting `Req` before `Ack` withdraws the request; no error.
  - `Req` may stay high after `Ack`; this requests the next packet.
- `Pkt0`/`Pkt1` changes after `Ack` do not affect the packet in flight.
- `Busy` = (state ≠ IDLE).
- All outputs are registered. Widths: byte counter `$clog2(PKT_BYTES)`, guard counter `$clog2(GUARD_CYCLES+1)`.

## Timing
- Reset values: all outputs 0, state IDLE, shift register 0, `Owner`=0, last-owner register=1.
- Request sampled high at edge c: `Ack`, `EnTrans`, byte 0 and `Busy` all appear in cycle c+1.
- Byte pacing: the next `EnTrans` comes 1 cycle after `TransBusy` is first sampled low in WAIT. Minimum spacing is `GUARD_CYCLES`+2 cycles.
- `Done` is high in the same cycle the state returns to IDLE. The next `Ack` comes at the earliest 1 cycle after `Done`.
- `TransData` holds the last byte until the next `EnTrans`.
- `TransBusy` high during HOLD has no effect. `TransBusy` low throughout WAIT advances after 1 cycle.
- Request arrival while the arbiter is busy: the request waits and is never dropped.
- Reset mid-packet: asynchronous return to IDLE, outputs cleared, the partial packet is discarded and no `Done` is issued.

## Configuration
- `TX_ARB_ROUND_ROBIN_EN` defined:
  - When both `Req` are high, the requester not served last wins.
  - The last-owner register updates on each `Ack`; its reset value of 1 means requester 0 wins the first tie.
- Not defined: fixed priority (requester 0); the last-owner register is absent.

## Test plan
Settings: `PKT_BYTES`=9, `GUARD_CYCLES`=2; the transmitter model raises busy 1 cycle after `te` and holds it for 10 cycles.
- `Req0` with `Pkt0`=0x0807060504030201_FF → `Ack0` in the next cycle; 9 `EnTrans` pulses carrying FF,01..08 in order; `Done` once; `Owner`=0.
- `Req0` and `Req1` held high for 4 packets → without the macro, 4×`Ack0` and `Ack1` never; with `TX_ARB_ROUND_ROBIN_EN`, `Ack` order 0,1,0,1.
- `Req1` raised during the 5th byte of a requester-0 packet → `Ack1` exactly 1 cycle after `Done`; requester-0 bytes are not interleaved.
- `TransBusy` held high in IDLE for 20 cycles with `Req0`=1 → no `Ack0` until busy drops; `Ack0` follows 1 cycle later.
- `rst` pulsed after the 3rd byte → `EnTrans`/`Busy`/`Done` go 0 immediately; a new `Req0` restarts the packet at byte FF.
- `Req0` dropped in the same cycle `Req1` rises while busy → `Ack0` is never issued; `Ack1` follows `Done`.
